// File: rtl/xalu_serial.sv
// xalu_serial: multi-cycle WIDTH-bit ALU built from one SLICE-bit datapath.
// A single slice is reused NS = WIDTH/SLICE times. The carry (ADD) or the
// shifted-out bit (SHL/SHR) is chained between cycles in c_q. Results and
// status flags are registered and held between operations.
module xalu_serial #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic             com_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             ci_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] y_o,
    output logic             co_o,
    output logic             zero_o,
    output logic             neg_zero_o,
    output logic             equ_o
);

    localparam int NS = WIDTH / SLICE;
    localparam int KW = (NS > 1) ? $clog2(NS) : 1;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_AND   = 3'd1;
    localparam logic [2:0] OP_OR    = 3'd2;
    localparam logic [2:0] OP_XOR   = 3'd3;
    localparam logic [2:0] OP_PASSA = 3'd4;
    localparam logic [2:0] OP_PASSB = 3'd5;
    localparam logic [2:0] OP_SHR   = 3'd6;
    localparam logic [2:0] OP_SHL   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Latched operation and running state
    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic [2:0]       op_q;
    logic             com_q;
    logic             c_q;
    logic [KW-1:0]    k_q;
    logic             zacc_q, oacc_q, eacc_q;

    // Held outputs
    logic [WIDTH-1:0] y_q;
    logic             co_q, zero_q, neg_q, equ_q;

    // Slice datapath signals
    logic [KW-1:0]    idx;
    logic [SLICE-1:0] a_s, b_s;
    logic [SLICE:0]   carry;
    logic [SLICE-1:0] sum_s, shl_s, shr_s;
    logic [SLICE-1:0] func_s, slice_out;
    logic             c_next;
    logic             co_final;
    logic             last;
    logic [WIDTH-1:0] res_next;
    logic             zacc_next, oacc_next, eacc_next;

    // SHR walks slices MSB-first so the shift-in bit travels downward.
    assign idx  = (op_q == OP_SHR) ? (KW'(NS - 1) - k_q) : k_q;
    assign a_s  = a_q[idx*SLICE +: SLICE];
    assign b_s  = b_q[idx*SLICE +: SLICE];
    assign last = (k_q == KW'(NS - 1));

    assign carry[0] = c_q;

    // Per-bit slice logic: ripple adder plus the neighbour taps for shifts.
    generate
        for (genvar gi = 0; gi < SLICE; gi++) begin : g_bit
            assign sum_s[gi]    = a_s[gi] ^ b_s[gi] ^ carry[gi];
            assign carry[gi+1]  = (a_s[gi] & b_s[gi]) | (carry[gi] & (a_s[gi] ^ b_s[gi]));
            if (gi == 0) begin : g_shl_lo
                assign shl_s[gi] = c_q;
            end else begin : g_shl_hi
                assign shl_s[gi] = a_s[gi-1];
            end
            if (gi == SLICE - 1) begin : g_shr_hi
                assign shr_s[gi] = c_q;
            end else begin : g_shr_lo
                assign shr_s[gi] = a_s[gi+1];
            end
        end
    endgenerate

    // Select the slice function and the next chain bit for the latched op.
    always_comb begin
        func_s = '0;
        c_next = c_q;
        case (op_q)
            OP_ADD: begin
                func_s = sum_s;
                c_next = carry[SLICE];
            end
            OP_AND:   func_s = a_s & b_s;
            OP_OR:    func_s = a_s | b_s;
            OP_XOR:   func_s = a_s ^ b_s;
            OP_PASSA: func_s = a_s;
            OP_PASSB: func_s = b_s;
            OP_SHR: begin
                func_s = shr_s;
                c_next = a_s[0];
            end
            OP_SHL: begin
                func_s = shl_s;
                c_next = a_s[SLICE-1];
            end
            default: func_s = '0;
        endcase
    end

    // Apply complement, merge the slice into the result and update the flags.
    always_comb begin
        slice_out = func_s ^ {SLICE{com_q}};
        res_next  = res_q;
        res_next[idx*SLICE +: SLICE] = slice_out;
        zacc_next = zacc_q & ~(|slice_out);
        oacc_next = oacc_q & (&slice_out);
        eacc_next = eacc_q & (a_s == b_s);
        // The carry/shift-out is only meaningful for arithmetic and shifts.
        co_final  = ((op_q == OP_ADD) || (op_q == OP_SHL) || (op_q == OP_SHR)) ? c_next : 1'b0;
    end

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: start only counts in IDLE, DONE lasts one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = S_RUN;
            S_RUN:   if (last) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Operand latch and per-slice iteration state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            com_q  <= 1'b0;
            c_q    <= 1'b0;
            k_q    <= '0;
            res_q  <= '0;
            zacc_q <= 1'b0;
            oacc_q <= 1'b0;
            eacc_q <= 1'b0;
        end else if (state_q == S_IDLE && start_i) begin
            a_q    <= a_i;
            b_q    <= b_i;
            op_q   <= op_i;
            com_q  <= com_i;
            c_q    <= ci_i;
            k_q    <= '0;
            res_q  <= '0;
            zacc_q <= 1'b1;
            oacc_q <= 1'b1;
            eacc_q <= 1'b1;
        end else if (state_q == S_RUN) begin
            res_q  <= res_next;
            c_q    <= c_next;
            k_q    <= k_q + KW'(1);
            zacc_q <= zacc_next;
            oacc_q <= oacc_next;
            eacc_q <= eacc_next;
        end
    end

    // Output registers load together on the final slice and hold afterwards.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            y_q    <= '0;
            co_q   <= 1'b0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            equ_q  <= 1'b0;
        end else if (state_q == S_RUN && last) begin
            y_q    <= res_next;
            co_q   <= co_final;
            zero_q <= zacc_next;
            neg_q  <= oacc_next;
            equ_q  <= eacc_next;
        end
    end

    assign busy_o     = (state_q == S_RUN);
    assign done_o     = (state_q == S_DONE);
    assign y_o        = y_q;
    assign co_o       = co_q;
    assign zero_o     = zero_q;
    assign neg_zero_o = neg_q;
    assign equ_o      = equ_q;

endmodule

// File: tb/tb_xalu_serial.sv
// tb_xalu_serial: directed and random checks of xalu_serial in three
// WIDTH/SLICE configurations against a full-width arithmetic reference.
module tb_xalu_serial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        st;
    int          cur;
    logic [2:0]  op;
    logic        com, ci;
    logic [15:0] a_r, b_r;

    logic start8, start12, start16;
    assign start8  = st && (cur == 0);
    assign start12 = st && (cur == 1);
    assign start16 = st && (cur == 2);

    logic        busy8, done8, co8, zero8, neg8, equ8;
    logic [7:0]  y8;
    logic        busy12, done12, co12, zero12, neg12, equ12;
    logic [11:0] y12;
    logic        busy16, done16, co16, zero16, neg16, equ16;
    logic [15:0] y16;

    xalu_serial #(.WIDTH(8), .SLICE(2)) u8 (
        .clk_i(clk), .rst_i(rst), .start_i(start8), .op_i(op), .com_i(com),
        .a_i(a_r[7:0]), .b_i(b_r[7:0]), .ci_i(ci), .busy_o(busy8), .done_o(done8),
        .y_o(y8), .co_o(co8), .zero_o(zero8), .neg_zero_o(neg8), .equ_o(equ8));

    xalu_serial #(.WIDTH(12), .SLICE(4)) u12 (
        .clk_i(clk), .rst_i(rst), .start_i(start12), .op_i(op), .com_i(com),
        .a_i(a_r[11:0]), .b_i(b_r[11:0]), .ci_i(ci), .busy_o(busy12), .done_o(done12),
        .y_o(y12), .co_o(co12), .zero_o(zero12), .neg_zero_o(neg12), .equ_o(equ12));

    xalu_serial #(.WIDTH(16), .SLICE(4)) u16 (
        .clk_i(clk), .rst_i(rst), .start_i(start16), .op_i(op), .com_i(com),
        .a_i(a_r), .b_i(b_r), .ci_i(ci), .busy_o(busy16), .done_o(done16),
        .y_o(y16), .co_o(co16), .zero_o(zero16), .neg_zero_o(neg16), .equ_o(equ16));

    // Observe the currently selected instance
    logic        obs_busy, obs_done, obs_co, obs_zero, obs_neg, obs_equ;
    logic [15:0] obs_y;
    always_comb begin
        obs_busy = busy16; obs_done = done16; obs_y = y16;
        obs_co = co16; obs_zero = zero16; obs_neg = neg16; obs_equ = equ16;
        case (cur)
            0: begin
                obs_busy = busy8; obs_done = done8; obs_y = {8'h00, y8};
                obs_co = co8; obs_zero = zero8; obs_neg = neg8; obs_equ = equ8;
            end
            1: begin
                obs_busy = busy12; obs_done = done12; obs_y = {4'h0, y12};
                obs_co = co12; obs_zero = zero12; obs_neg = neg12; obs_equ = equ12;
            end
            default: ;
        endcase
    end

    int checks = 0;
    int errors = 0;
    logic [15:0] ly;
    logic        lco, lz, ln, le;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int wid_of(input int w);
        return (w == 0) ? 8 : (w == 1) ? 12 : 16;
    endfunction

    function automatic int ns_of(input int w);
        return (w == 0) ? 4 : (w == 1) ? 3 : 4;
    endfunction

    // Reference: whole-word arithmetic straight from the function table
    task automatic model(input int w, input logic [2:0] o, input logic cm, input logic c,
                         input logic [15:0] av, input logic [15:0] bv,
                         output logic [15:0] r, output logic co_e, output logic z_e,
                         output logic n_e, output logic e_e);
        logic [16:0] mask, x, yb, s, cc, r17;
        mask = (17'd1 << w) - 17'd1;
        x    = {1'b0, av} & mask;
        yb   = {1'b0, bv} & mask;
        cc   = {16'd0, c};
        co_e = 1'b0;
        case (o)
            3'd0: begin
                s    = x + yb + cc;
                r17  = s & mask;
                co_e = s[w];
            end
            3'd1: r17 = x & yb;
            3'd2: r17 = x | yb;
            3'd3: r17 = x ^ yb;
            3'd4: r17 = x;
            3'd5: r17 = yb;
            3'd6: begin
                r17  = (x >> 1) | (cc << (w - 1));
                co_e = x[0];
            end
            default: begin
                r17  = ((x << 1) | cc) & mask;
                co_e = x[w-1];
            end
        endcase
        if (cm) r17 = r17 ^ mask;
        r   = r17[15:0];
        z_e = (r17 == 17'd0);
        n_e = (r17 == mask);
        e_e = (x == yb);
    endtask

    // One operation on instance `which`; optional stray start pulse or reset mid-RUN
    task automatic run_op(input int which, input logic [2:0] o, input logic cm, input logic c,
                          input logic [15:0] av, input logic [15:0] bv,
                          input int pulse_at, input int rst_at);
        logic [15:0] ey;
        logic        eco, ez, en, ee;
        int          n, busy_cnt;
        cur = which; op = o; com = cm; ci = c; a_r = av; b_r = bv; st = 1'b1;
        model(wid_of(which), o, cm, c, av, bv, ey, eco, ez, en, ee);
        @(posedge clk); #1;
        st = 1'b0;
        // Scramble inputs: only the latched copies may matter now
        a_r = 16'($urandom); b_r = 16'($urandom); op = 3'($urandom);
        com = 1'($urandom); ci = 1'($urandom);
        busy_cnt = obs_busy ? 1 : 0;
        n = 0;
        while (!obs_done && n < 20) begin
            if (n == pulse_at) st = 1'b1;
            @(posedge clk); #1;
            st = 1'b0;
            n++;
            if (n == rst_at) begin
                rst = 1'b1; #1;
                check("rst_busy", obs_busy, 0);
                check("rst_done", obs_done, 0);
                check("rst_y", obs_y, 0);
                check("rst_co", obs_co, 0);
                check("rst_zero", obs_zero, 0);
                check("rst_neg", obs_neg, 0);
                check("rst_equ", obs_equ, 0);
                @(posedge clk); #1;
                rst = 1'b0;
                for (int i = 0; i < 6; i++) begin
                    @(posedge clk); #1;
                    check("rst_no_done", obs_done, 0);
                end
                return;
            end
            if (obs_busy) busy_cnt++;
        end
        check("latency", n, ns_of(which));
        check("busy_cycles", busy_cnt, ns_of(which));
        check("y", obs_y, ey);
        check("co", obs_co, eco);
        check("zero", obs_zero, ez);
        check("neg_zero", obs_neg, en);
        check("equ", obs_equ, ee);
        ly = obs_y; lco = obs_co; lz = obs_zero; ln = obs_neg; le = obs_equ;
        @(posedge clk); #1;
        check("done_pulse_end", obs_done, 0);
        check("y_hold", obs_y, ey);
        if (pulse_at >= 0) begin
            @(posedge clk); #1;
            check("no_queued_start", obs_busy, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [15:0] ra, rb;
        rst = 1'b1; st = 1'b0; cur = 2; op = '0; com = 1'b0; ci = 1'b0;
        a_r = '0; b_r = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            cur = k; #1;
            check("reset_busy", obs_busy, 0);
            check("reset_done", obs_done, 0);
            check("reset_y", obs_y, 0);
            check("reset_flags", {obs_co, obs_zero, obs_neg, obs_equ}, 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases on the 16/4 instance
        run_op(2, 3'd0, 1'b0, 1'b0, 16'hFFFF, 16'h0001, -1, -1);
        check("add_wrap_y", ly, 16'h0000);
        check("add_wrap_co", lco, 1);
        check("add_wrap_zero", lz, 1);
        check("add_wrap_equ", le, 0);
        run_op(2, 3'd0, 1'b1, 1'b1, 16'h1234, 16'h1111, -1, -1);
        check("add_com_y", ly, 16'hDCB9);
        check("add_com_flags", {lco, lz, ln}, 0);
        run_op(2, 3'd7, 1'b0, 1'b1, 16'h8001, 16'h0000, -1, -1);
        check("shl_y", ly, 16'h0003);
        check("shl_co", lco, 1);
        run_op(2, 3'd6, 1'b0, 1'b0, 16'h8001, 16'h0000, -1, -1);
        check("shr_y", ly, 16'h4000);
        check("shr_co", lco, 1);
        run_op(2, 3'd3, 1'b0, 1'b0, 16'hA5A5, 16'hA5A5, -1, -1);
        check("xor_eq_y", ly, 16'h0000);
        check("xor_eq_flags", {lz, le}, 2'b11);
        run_op(2, 3'd4, 1'b0, 1'b1, 16'hFFFF, 16'h0000, -1, -1);
        check("passa_neg", ln, 1);
        check("passa_co", lco, 0);
        run_op(2, 3'd1, 1'b1, 1'b0, 16'h0F0F, 16'h00FF, -1, -1);
        check("and_com_y", ly, 16'hFFF0);
        run_op(2, 3'd0, 1'b0, 1'b0, 16'h1234, 16'h4321, 2, -1);
        check("ignored_start_y", ly, 16'h5555);
        run_op(2, 3'd0, 1'b0, 1'b0, 16'h0001, 16'h0001, -1, 3);
        run_op(2, 3'd3, 1'b0, 1'b0, 16'hF0F0, 16'h0FF0, -1, -1);
        check("after_rst_y", ly, 16'hFF00);

        // Random operations on every configuration
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < 1000; i++) begin
                ra = 16'($urandom);
                rb = ($urandom_range(0, 7) == 0) ? ra : 16'($urandom);
                if ($urandom_range(0, 15) == 0) ra = 16'hFFFF;
                run_op(w, 3'($urandom), 1'($urandom), 1'($urandom), ra, rb, -1, -1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/xalu_serial.md
# xalu_serial

Parametrised multi-cycle successor to the 4-bit ALU slice. One SLICE-bit ALU datapath is reused over WIDTH/SLICE clock cycles to compute an 8-function, WIDTH-bit operation, with the carry or shift bit chained between cycles in a register. A start/busy/done handshake brackets each operation. Results and status flags are registered and held between operations. The block sits between the operand registers and the result bus of small TinyTapeout-class datapaths.

## Interface
- WIDTH, 16, operand and result width; must be an integer multiple of SLICE.
- SLICE, 4, bits processed per cycle; NS = WIDTH/SLICE must be ≥ 2.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request an operation; sampled only in IDLE.
- op  in  3  function: 0 ADD, 1 AND, 2 OR, 3 XOR, 4 PASSA, 5 PASSB, 6 SHR, 7 SHL.
- com  in  1  ones'-complement output mode; result is inverted.
- a, b  in  WIDTH  operands.
- ci  in  1  carry-in for ADD; shift-in bit for SHL (into y[0]) and SHR (into y[WIDTH-1]).
- busy  out  1  high while state is RUN.
- done  out  1  one-cycle pulse when results are updated.
- y  out  WIDTH  result.
- co  out  1  ADD: carry out of bit WIDTH-1; SHL: a[WIDTH-1]; SHR: a[0]; other ops: 0.
- zero  out  1  y is all zeros (after com).
- neg_zero  out  1  y is all ones (after com).
- equ  out  1  a == b for the latched operands.

## Operation
- States: IDLE, RUN, DONE. Reset puts the FSM in IDLE.
- IDLE with start=1: latch a, b, op, com and ci; clear the slice counter k; go to RUN.
- IDLE with start=0: stay in IDLE.
- start is ignored in RUN and DONE; it is never queued.
- RUN: one slice per cycle.
  - Order is LSB-first (k=0 covers bits SLICE-1..0) for every op except SHR.
  - SHR runs MSB-first.
- Chain register c, loaded with the latched ci at start:
  - ADD: c ← slice carry out.
  - SHL: c ← MSB of the current a slice.
  - SHR: c ← LSB of the current a slice.
  - Logic and pass ops leave c unused.
- Per slice, for each bit i: ADD gives a^b^carry, using ripple inside the slice with c feeding bit 0.
  - AND, OR, XOR: bitwise on a and b.
  - PASSA, PASSB: a or b.
  - SHL: bit i takes a[i-1], with c entering the lowest bit.
  - SHR: bit i takes a[i+1], with c entering the highest bit.
- Each slice result is XORed with com, then written into an internal result register.
- Running flags accumulate per slice: all-zero, all-one, and a==b.
- After slice NS-1 the FSM goes to DONE.
  - On that same edge, y, co, zero, neg_zero and equ load from the internal registers, and done becomes 1.
- DONE → IDLE unconditionally after one cycle.
- The outputs then hold until the next DONE.
- Arithmetic is unsigned modulo 2^WIDTH; the overflow bit appears only on co.
- co is not affected by com.

## Timing
- Reset values: busy=0, done=0, y=0, co=0, zero=0, neg_zero=0, equ=0; state IDLE; internal registers 0.
- Edge E0 samples start=1 in IDLE.
  - busy is high from E0 through edge E0+NS, for NS cycles.
  - done is high for the single cycle following edge E0+NS.
  - y and the flags are valid from that same cycle.
- Latency from start to done is NS+1 cycles. Minimum start-to-start spacing is NS+2 cycles.
- Operands may change freely after E0; only the latched copies are used.
- rst asserted mid-RUN or in DONE:
  - Immediately aborts the operation.
  - Forces every output to its reset value.
  - No done pulse is produced for the aborted operation.
- start held high continuously: a new operation is accepted at each IDLE cycle, i.e. every NS+2 cycles.

## Test plan
- WIDTH=16, SLICE=4, ADD a=0xFFFF b=0x0001 ci=0 → busy 4 cycles; done in the 5th cycle after E0; y=0x0000, co=1, zero=1, equ=0.
- ADD a=0x1234 b=0x1111 ci=1 com=1 → y=0xDCB9, co=0, zero=0, neg_zero=0.
- SHL a=0x8001 ci=1 → y=0x0003, co=1. SHR a=0x8001 ci=0 → y=0x4000, co=1.
- XOR a=b=0xA5A5 → y=0x0000, zero=1, equ=1. PASSA a=0xFFFF → neg_zero=1, co=0. AND with com=1, a=0x0F0F b=0x00FF → y=0xFFF0.
- Pulse start again 2 cycles into RUN → ignored; result matches the first op. Assert rst in RUN cycle 3 → busy=0 at once, no done, outputs 0. Next start completes normally.
- WIDTH=8, SLICE=2 and WIDTH=12, SLICE=4: 1000 random ops/com/ci checked against a full-width reference model, including every co and flag value.
